aes_pipe_ctrl: RTL and testbench

- Flow-control wrapper and sequencer for the free-running 10-round pipelined AES-128 encryption core `aes_cipher`.
- The core itself has no valid, stall or handshake. This block adds a valid/ready input stream and a valid/ready output stream.
- It tracks blocks in flight with a valid shift register and buffers results in an output FIFO. Credit-based issue guarantees no result is ever lost.
- It serialises key changes: the pipeline is drained before the core's key input is updated.

---
 rtl/aes_pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_aes_pipe_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_pipe_ctrl.sv
// Flow-control wrapper around the free-running 10-round AES-128 pipeline core.
// Adds valid/ready streams, credit-based issue, an output FIFO and drained key changes.
`timescale 1ns/1ps
module aes_pipe_ctrl #(
    parameter int LATENCY = 11,
    parameter int DEPTH   = 16,
    parameter int CW      = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         key_busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] aes_datain,
    output logic [127:0] aes_key,
    input  logic [127:0] aes_dataout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, KEYSET} state_t;

    state_t               state_q, state_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         shadow_q, shadow_d;
    logic [LATENCY-1:0]   vpipe_q, vpipe_d;
    logic [CW-1:0]        inflight_q, inflight_d;
    logic [CW-1:0]        occ_q, occ_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic                 en_q, en_d;
    logic [127:0]         mem_q [DEPTH];

    logic                 credit_ok;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic [CW:0]          credit_sum;

    // Everything issued but not yet consumed holds a credit, so a push always finds room.
    assign credit_sum = {1'b0, inflight_q} + {1'b0, occ_q};
    assign credit_ok  = credit_sum < (CW+1)'(DEPTH);

    assign in_ready   = en_q && (state_q == RUN) && !key_load && credit_ok;
    assign accept     = in_valid && in_ready;
    assign push       = vpipe_q[LATENCY-1];
    assign out_valid  = (occ_q != '0);
    assign pop        = out_valid && out_ready;
    assign out_data   = out_valid ? mem_q[rd_q] : '0;
    assign key_busy   = (state_q != RUN);
    assign aes_datain = in_data;
    assign aes_key    = key_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        shadow_d   = shadow_q;
        en_d       = 1'b1;
        vpipe_d    = {vpipe_q[LATENCY-2:0], accept};
        inflight_d = inflight_q;
        occ_d      = occ_q;
        rd_d       = pop  ? ptr_inc(rd_q) : rd_q;
        wr_d       = push ? ptr_inc(wr_q) : wr_q;

        if (accept && !push) begin
            inflight_d = inflight_q + 1'b1;
        end else if (!accept && push) begin
            inflight_d = inflight_q - 1'b1;
        end

        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end

        case (state_q)
            RUN: begin
                if (key_load) begin
                    shadow_d = key_in;
                    state_d  = (inflight_q == '0) ? KEYSET : DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) begin
                    state_d = KEYSET;
                end
            end
            KEYSET: begin
                key_d   = shadow_q;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            key_q      <= '0;
            shadow_q   <= '0;
            en_q       <= 1'b0;
            vpipe_q    <= '0;
            inflight_q <= '0;
            occ_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            shadow_q   <= shadow_d;
            en_q       <= en_d;
            vpipe_q    <= vpipe_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= aes_dataout;
        end
    end
endmodule

// File: tb/tb_aes_pipe_ctrl.sv
// Bench for aes_pipe_ctrl: drives the wrapper against a delayed reference AES-128 core
// and checks every delivered block against ciphertexts computed at accept time.
`timescale 1ns/1ps
module tb_aes_pipe_ctrl;
  localparam int LAT   = 11;
  localparam int DEPTH = 16;

  logic         clk;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_load;
  logic         key_busy;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] aes_datain;
  logic [127:0] aes_key;
  logic [127:0] aes_dataout;

  aes_pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load), .key_busy(key_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .aes_datain(aes_datain), .aes_key(aes_key), .aes_dataout(aes_dataout)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference AES-128 ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [7:0] l;
    logic [7:0] r;
    l = x << n;
    r = x >> (8 - n);
    return l | r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
  end

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int k = 0; k < 16; k++) s[k] = pt[127-8*k -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int k = 0; k < 16; k++) t[k] = sb[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = s[k];
    return res;
  endfunction

  // Free-running core stand-in: captures datain/key on every edge, result LAT-1 edges later.
  logic [127:0] core_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
    core_pipe[0] <= aes_enc(aes_datain, aes_key);
  end
  assign aes_dataout = core_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q [$];
  logic [127:0] tb_key = '0;
  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int pop_cnt = 0;
  int acc_edge = 0;
  int last_wait = 0;
  int pops_at_acc = 0;
  bit stream_track = 0;
  bit stream_seen = 0;
  int stream_pops = 0;
  int stream_gaps = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      check("occ_le_depth", 128'(dut.occ_q <= DEPTH), 128'd1);
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_output: observed %h expected no output", out_data);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        exp_q.push_back(aes_enc(in_data, tb_key));
      end
      if (stream_track) begin
        if (out_valid) begin
          stream_seen = 1;
          stream_pops++;
        end else if (stream_seen && stream_pops < 32) begin
          stream_gaps++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Holds in_valid high until accepted; caller decides when to drop it.
  task automatic send(input logic [127:0] d, output bit ok);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    ok = 0;
    n  = 0;
    while (!ok && n < 64) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        acc_edge = cyc + 1;
        pops_at_acc = pop_cnt;
      end
      @(posedge clk);
      #1;
      n++;
    end
    last_wait = n;
    if (!ok) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed no accept in %0d cycles, expected accept", n);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    int n;
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    tb_key   = k;
    n = 0;
    while (key_busy && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("key_load_done", 128'(key_busy), 128'd0);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // ---------------- directed sequence ----------------
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K3  = 128'hfedcba98765432100123456789abcdef;

  initial begin
    bit ok;
    int n;
    int stalls;
    int a0;
    int p0;
    int ov_cnt;
    rst_n = 1'b0; key_in = '0; key_load = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd0);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_key_busy", 128'(key_busy), 128'd0);
    check("rst_out_data", out_data, 128'd0);
    check("rst_aes_key", aes_key, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 C.1 single block, latency from accept edge
    load_key(K1);
    check("key1_applied", aes_key, K1);
    send(PT1, ok);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    check("fips_latency", 128'(cyc - acc_edge), 128'(LAT));
    check("fips_ct", out_data, CT1);
    @(posedge clk);
    #1;
    wait_empty();

    // 32 back-to-back blocks with out_ready=1
    stream_track = 1; stream_seen = 0; stream_pops = 0; stream_gaps = 0; stalls = 0;
    for (int i = 0; i < 32; i++) begin
      send(rand128(), ok);
      stalls += last_wait - 1;
    end
    in_valid = 1'b0;
    wait_empty();
    stream_track = 0;
    check("stream_stalls", 128'(stalls), 128'd0);
    check("stream_results", 128'(stream_pops), 128'd32);
    check("stream_gaps", 128'(stream_gaps), 128'd0);

    // backpressure: credit stops issue at DEPTH outstanding
    out_ready = 1'b0;
    a0 = acc_cnt;
    in_valid = 1'b1;
    in_data = rand128();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) in_data = rand128();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 128'(acc_cnt - a0), 128'(DEPTH));
    check("bp_in_ready", 128'(in_ready), 128'd0);
    check("bp_out_valid", 128'(out_valid), 128'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_empty();
    send(rand128(), ok);
    in_valid = 1'b0;
    check("bp_resume", 128'(ok), 128'd1);
    wait_empty();

    // key change with 5 blocks in flight
    for (int i = 0; i < 5; i++) send(rand128(), ok);
    in_valid = 1'b0;
    p0 = pop_cnt;
    key_in = K2;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    tb_key = K2;
    @(negedge clk);
    check("kc_busy", 128'(key_busy), 128'd1);
    check("kc_old_key_held", aes_key, K1);
    @(posedge clk);
    #1;
    send(rand128(), ok);
    in_valid = 1'b0;
    check("kc_old_drained", 128'(pops_at_acc - p0), 128'd5);
    check("kc_new_key", aes_key, K2);
    wait_empty();

    // key_load and in_valid together with an empty pipe
    repeat (3) @(posedge clk);
    #1;
    a0 = acc_cnt;
    key_in = K3;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_data = rand128();
    @(negedge clk);
    check("kl_wins_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1;
    key_load = 1'b0;
    tb_key = K3;
    @(negedge clk);
    check("kl_keyset_busy", 128'(key_busy), 128'd1);
    check("kl_keyset_ready", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("kl_run_ready", 128'(in_ready), 128'd1);
    check("kl_key3", aes_key, K3);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("kl_one_accept", 128'(acc_cnt - a0), 128'd1);
    wait_empty();

    // reset with 8 blocks in flight
    for (int i = 0; i < 8; i++) send(rand128(), ok);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_aes_key", aes_key, 128'd0);
    check("mid_rst_key_busy", 128'(key_busy), 128'd0);
    exp_q.delete();
    tb_key = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("post_rst_no_output", 128'(ov_cnt), 128'd0);
    @(posedge clk);
    #1;
    send(PT1, ok);
    in_valid = 1'b0;
    wait_empty();
    check("final_queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
